if_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register. It is the consumer of the hazard

---
 rtl/if_stage.sv | 149 ++++++++++++++
 tb/tb_if_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem request/response
// port and feeds the IF/ID pipeline register with stall, flush and redirect handling.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        if_id_flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        hold_v_q, hold_v_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] if_id_pc_d, if_id_instr_d;
  logic        if_id_valid_d;

  logic        handshake;
  logic        take;
  logic        fill;
  logic [31:0] fill_instr;

  assign imem_req  = rst_n && (state_q == S_REQ);
  assign imem_addr = pc_q & 32'hFFFF_FFFC;
  assign handshake = imem_req && imem_ready;
  // IF/ID may only be written when decode is not stalled and nothing is being killed
  assign take      = if_id_write && !if_id_flush && !redirect;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    hold_v_d      = hold_v_q;
    hold_instr_d  = hold_instr_q;
    if_id_pc_d    = if_id_pc;
    if_id_instr_d = if_id_instr;
    if_id_valid_d = if_id_valid;
    fill          = 1'b0;
    fill_instr    = NOP_INSTR;

    if (redirect) begin
      pc_d     = redirect_pc & 32'hFFFF_FFFC;
      hold_v_d = 1'b0;
      unique case (state_q)
        S_REQ: begin
          if (handshake) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          // a response arriving now is the stale one; otherwise it is still owed
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (handshake) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else if (take) begin
              fill       = 1'b1;
              fill_instr = imem_rdata;
              state_d    = S_REQ;
            end else begin
              hold_instr_d = imem_rdata;
              hold_v_d     = 1'b1;
              state_d      = S_HOLD;
            end
          end
        end
        default: begin
          if (take && hold_v_q) begin
            fill       = 1'b1;
            fill_instr = hold_instr_q;
            hold_v_d   = 1'b0;
            state_d    = S_REQ;
          end
        end
      endcase
      if (fill && pc_write) pc_d = pc_q + 32'd4;
    end

    // IF/ID: flush kills, redirect blocks writes, otherwise load new data or a bubble
    if (if_id_flush) begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
    end else if (!redirect) begin
      if (fill) begin
        if_id_pc_d    = pc_q;
        if_id_instr_d = fill_instr;
        if_id_valid_d = 1'b1;
      end else if (if_id_write) begin
        if_id_valid_d = 1'b0;
        if_id_instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      hold_v_q     <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      if_id_pc     <= '0;
      if_id_instr  <= NOP_INSTR;
      if_id_valid  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      hold_v_q     <= hold_v_d;
      hold_instr_q <= hold_instr_d;
      if_id_pc     <= if_id_pc_d;
      if_id_instr  <= if_id_instr_d;
      if_id_valid  <= if_id_valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed per-cycle vector bench for if_stage: a hand-computed table covers fetch, stall,
// flush/redirect and reset-mid-transaction; a second instance covers RESET_PC wrap-around.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n, pc_write, if_id_write, if_id_flush, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_id_pc, if_id_instr;
  logic        if_id_valid;

  logic        rst2_n, req2, ready2, rvalid2, valid2;
  logic [31:0] addr2, rdata2, pc2, instr2;

  int checks = 0;
  int errors = 0;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .pc_write(1'b1), .if_id_write(1'b1),
    .if_id_flush(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .imem_req(req2), .imem_addr(addr2), .imem_ready(ready2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .if_id_pc(pc2), .if_id_instr(instr2), .if_id_valid(valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, pw, iw, fl, rd;
    logic [31:0] rpc;
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ev;
    logic [31:0] epc, eins;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic rst, pw, iw, fl, rd, input logic [31:0] rpc,
    input logic rdy, rv, input logic [31:0] rdata,
    input logic ereq, input logic [31:0] eaddr, input logic ev,
    input logic [31:0] epc, eins);
    vec_t v;
    v.rst = rst; v.pw = pw; v.iw = iw; v.fl = fl; v.rd = rd; v.rpc = rpc;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata;
    v.ereq = ereq; v.eaddr = eaddr; v.ev = ev; v.epc = epc; v.eins = eins;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  initial begin
    //            rst pw iw fl rd rpc          rdy rv rdata          req addr         v  pc           instr
    tbl[0]  = mk(1, 1, 1, 0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h0,       0, 32'h0,       NOP);
    tbl[1]  = mk(1, 1, 1, 0, 0, 32'h0,       0, 1, 32'h00A00093, 0, 32'h0,       0, 32'h0,       NOP);
    tbl[2]  = mk(1, 1, 1, 0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h4,       1, 32'h0,       32'h00A00093);
    tbl[3]  = mk(1, 1, 1, 0, 0, 32'h0,       0, 1, 32'h00100113, 0, 32'h4,       0, 32'h0,       NOP);
    tbl[4]  = mk(1, 0, 0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h8,       1, 32'h4,       32'h00100113);
    tbl[5]  = mk(1, 0, 0, 0, 0, 32'h0,       0, 1, 32'h00200193, 0, 32'h8,       1, 32'h4,       32'h00100113);
    tbl[6]  = mk(1, 0, 0, 0, 0, 32'h0,       1, 0, 32'h0,        0, 32'h8,       1, 32'h4,       32'h00100113);
    tbl[7]  = mk(1, 1, 1, 0, 0, 32'h0,       0, 0, 32'h0,        0, 32'h8,       1, 32'h4,       32'h00100113);
    tbl[8]  = mk(1, 1, 0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 32'hC,       1, 32'h8,       32'h00200193);
    tbl[9]  = mk(1, 1, 0, 0, 0, 32'h0,       0, 0, 32'h0,        0, 32'hC,       1, 32'h8,       32'h00200193);
    tbl[10] = mk(1, 1, 0, 1, 1, 32'h102,     0, 0, 32'h0,        0, 32'hC,       1, 32'h8,       32'h00200193);
    tbl[11] = mk(1, 1, 1, 0, 0, 32'h0,       0, 0, 32'h0,        0, 32'h100,     0, 32'h8,       NOP);
    tbl[12] = mk(1, 1, 1, 0, 0, 32'h0,       0, 1, 32'hDEADBEEF, 0, 32'h100,     0, 32'h8,       NOP);
    tbl[13] = mk(1, 1, 1, 0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h100,     0, 32'h8,       NOP);
    tbl[14] = mk(1, 1, 1, 0, 0, 32'h0,       0, 1, 32'h00300213, 0, 32'h100,     0, 32'h8,       NOP);
    tbl[15] = mk(1, 1, 1, 1, 1, 32'h8,       0, 0, 32'h0,        1, 32'h104,     1, 32'h100,     32'h00300213);
    tbl[16] = mk(1, 1, 1, 1, 1, 32'h200,     1, 0, 32'h0,        1, 32'h8,       0, 32'h100,     NOP);
    tbl[17] = mk(1, 1, 1, 0, 0, 32'h0,       0, 1, 32'h0BAD0BAD, 0, 32'h200,     0, 32'h100,     NOP);
    tbl[18] = mk(1, 1, 1, 0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h200,     0, 32'h100,     NOP);
    tbl[19] = mk(1, 1, 1, 0, 0, 32'h0,       0, 1, 32'h00400293, 0, 32'h200,     0, 32'h100,     NOP);
    tbl[20] = mk(1, 0, 1, 0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h204,     1, 32'h200,     32'h00400293);
    tbl[21] = mk(1, 0, 1, 0, 0, 32'h0,       0, 1, 32'h00500313, 0, 32'h204,     0, 32'h200,     NOP);
    tbl[22] = mk(1, 1, 0, 0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h204,     1, 32'h204,     32'h00500313);
    tbl[23] = mk(0, 1, 1, 0, 0, 32'h0,       0, 1, 32'h00000BAD, 0, 32'h204,     1, 32'h204,     32'h00500313);
    tbl[24] = mk(0, 1, 1, 0, 0, 32'h0,       1, 1, 32'h00000BAD, 0, 32'h0,       0, 32'h0,       NOP);
    tbl[25] = mk(1, 1, 1, 0, 0, 32'h0,       0, 1, 32'h00000BAD, 1, 32'h0,       0, 32'h0,       NOP);
    tbl[26] = mk(1, 1, 1, 0, 0, 32'h0,       1, 0, 32'h0,        1, 32'h0,       0, 32'h0,       NOP);
    tbl[27] = mk(1, 1, 1, 0, 0, 32'h0,       0, 1, 32'h00600393, 0, 32'h0,       0, 32'h0,       NOP);
    tbl[28] = mk(1, 1, 1, 0, 0, 32'h0,       0, 0, 32'h0,        1, 32'h4,       1, 32'h0,       32'h00600393);

    rst_n = 1'b0; pc_write = 1'b1; if_id_write = 1'b1; if_id_flush = 1'b0;
    redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    rst2_n = 1'b0; ready2 = 1'b0; rvalid2 = 1'b0; rdata2 = '0;

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_req", -1, {31'b0, imem_req}, 32'h0);
    chk("reset_valid", -1, {31'b0, if_id_valid}, 32'h0);
    chk("reset_instr", -1, if_id_instr, NOP);
    chk("reset_pc", -1, if_id_pc, 32'h0);
    chk("reset_addr", -1, imem_addr, 32'h0);

    for (int i = 0; i < NV; i++) begin
      rst_n       = tbl[i].rst;
      pc_write    = tbl[i].pw;
      if_id_write = tbl[i].iw;
      if_id_flush = tbl[i].fl;
      redirect    = tbl[i].rd;
      redirect_pc = tbl[i].rpc;
      imem_ready  = tbl[i].rdy;
      imem_rvalid = tbl[i].rv;
      imem_rdata  = tbl[i].rdata;
      #1;
      chk("imem_req", i, {31'b0, imem_req}, {31'b0, tbl[i].ereq});
      chk("imem_addr", i, imem_addr, tbl[i].eaddr);
      chk("if_id_valid", i, {31'b0, if_id_valid}, {31'b0, tbl[i].ev});
      chk("if_id_pc", i, if_id_pc, tbl[i].epc);
      chk("if_id_instr", i, if_id_instr, tbl[i].eins);
      @(negedge clk);
    end

    // RESET_PC near the top of the address space: the fetch after it wraps to 0
    @(negedge clk);
    #1;
    chk("wrap_reset_req", 100, {31'b0, req2}, 32'h0);
    rst2_n = 1'b1; ready2 = 1'b1;
    #1;
    chk("wrap_req0", 101, {31'b0, req2}, 32'h1);
    chk("wrap_addr0", 101, addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    ready2 = 1'b0; rvalid2 = 1'b1; rdata2 = 32'h0070_0413;
    #1;
    chk("wrap_req_wait", 102, {31'b0, req2}, 32'h0);
    @(negedge clk);
    ready2 = 1'b1; rvalid2 = 1'b0; rdata2 = '0;
    #1;
    chk("wrap_addr1", 103, addr2, 32'h0);
    chk("wrap_req1", 103, {31'b0, req2}, 32'h1);
    chk("wrap_valid", 103, {31'b0, valid2}, 32'h1);
    chk("wrap_if_id_pc", 103, pc2, 32'hFFFF_FFFC);
    chk("wrap_if_id_instr", 103, instr2, 32'h0070_0413);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
